particle_dispatch: RTL and testbench

- Frame-level sequencer and round-robin arbiter between the particle source stream and NUM_LANES parallel render lanes.
- Runs one frame per frame_start:
  - pulls exactly NUM_PARTICLES 48-bit particle words from the source with a busy/valid handshake;
  - buffers them in a 2-entry skid FIFO;
  - hands each word to one ready lane;
  - signals frame_done once all lanes have drained.

---
 rtl/particle_dispatch.sv | 222 ++++++++++++++++++++++
 tb/tb_particle_dispatch.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/particle_dispatch.sv
// particle_dispatch: frame sequencer that pulls NUM_PARTICLES words from the
// particle source into a 2-entry skid FIFO and hands them round-robin to
// NUM_LANES render lanes, pulsing frame_done once every lane has drained.
module particle_dispatch #(
    parameter int NUM_PARTICLES = 200,
    parameter int NUM_LANES     = 2,
    parameter int DATA_WIDTH    = 48
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  frame_start_in,
    input  logic [DATA_WIDTH-1:0] p_in,
    input  logic                  p_valid_in,
    output logic                  busy_out,
    output logic [DATA_WIDTH-1:0] lane_data_out,
    output logic [NUM_LANES-1:0]  lane_valid_out,
    input  logic [NUM_LANES-1:0]  lane_ready_in,
    input  logic [NUM_LANES-1:0]  lane_busy_in,
    output logic                  frame_active_out,
    output logic                  frame_done_out,
    output logic [15:0]           dispatch_count_out
);

    localparam int              PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [15:0]     NP    = 16'(NUM_PARTICLES);
    localparam logic [PTR_W:0]  NL    = (PTR_W + 1)'(NUM_LANES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Lane index after idx, wrapping at NUM_LANES (always 0 for a single lane).
    function automatic logic [PTR_W-1:0] f_lane_next(input logic [PTR_W-1:0] idx);
        logic [PTR_W:0] v_inc;
        v_inc = {1'b0, idx} + {{PTR_W{1'b0}}, 1'b1};
        if (v_inc >= NL) begin
            f_lane_next = '0;
        end else begin
            f_lane_next = v_inc[PTR_W-1:0];
        end
    endfunction

    state_t                  r_state;
    state_t                  w_next_state;

    // Skid FIFO storage and control.
    logic [DATA_WIDTH-1:0]   r_mem [0:1];
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_fifo_count;

    // Frame bookkeeping.
    logic                    r_inflight;
    logic [15:0]             r_req_count;
    logic [15:0]             r_dispatch_count;
    logic [PTR_W-1:0]        r_rr_ptr;

    logic                    w_fifo_empty;
    logic                    w_fifo_full;
    logic                    w_room;
    logic                    w_req;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_frame_go;
    logic                    w_frame_active;
    logic                    w_frame_done;

    // Arbiter.
    logic [2*NUM_LANES-1:0]  w_ready_rot;
    logic                    w_grant_found;
    logic [PTR_W-1:0]        w_grant_off;
    logic [PTR_W:0]          w_grant_sum;
    logic [PTR_W-1:0]        w_grant;
    logic [NUM_LANES-1:0]    w_lane_valid;

    assign w_fifo_empty = (r_fifo_count == 2'd0);
    assign w_fifo_full  = (r_fifo_count == 2'd2);

    // One word may already be on its way from the source; only request
    // another if both the stored words and that in-flight word still fit.
    assign w_room = (r_fifo_count == 2'd0) ||
                    ((r_fifo_count == 2'd1) && !r_inflight);

    assign w_frame_go = (r_state == S_IDLE) && frame_start_in;

    // Words are accepted only while streaming; anything arriving in other
    // states (including late words after a reset) is dropped.
    assign w_push = (r_state == S_STREAM) && p_valid_in && (!w_fifo_full || w_pop);

    // Round-robin grant: rotate the ready vector so rr_ptr sits at bit 0,
    // take the lowest set bit, then map the offset back to a lane index.
    always_comb begin
        w_ready_rot   = {lane_ready_in, lane_ready_in} >> r_rr_ptr;
        w_grant_found = 1'b0;
        w_grant_off   = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (w_ready_rot[k]) begin
                w_grant_found = 1'b1;
                w_grant_off   = PTR_W'(k);
            end
        end
        w_grant_sum = {1'b0, r_rr_ptr} + {1'b0, w_grant_off};
        if (w_grant_sum >= NL) begin
            w_grant_sum = w_grant_sum - NL;
        end
        w_grant = w_grant_sum[PTR_W-1:0];
    end

    // A granted lane is by construction ready, so a grant is a transfer.
    assign w_pop        = !w_fifo_empty && w_grant_found;
    assign w_lane_valid = w_pop ? (NUM_LANES'(1) << w_grant) : '0;

    // Frame state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the per-state source request and frame flags.
    always_comb begin
        w_next_state   = r_state;
        w_req          = 1'b0;
        w_frame_active = 1'b0;
        w_frame_done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (frame_start_in) begin
                    w_next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                w_frame_active = 1'b1;
                w_req          = (r_req_count < NP) && w_room;
                if (r_dispatch_count == NP) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_frame_active = 1'b1;
                if ((lane_busy_in == '0) && (w_lane_valid == '0)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_frame_done = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the
    // count unchanged. Reset flushes whatever the abandoned frame left.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_fifo_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + 2'd1;
                2'b01:   r_fifo_count <= r_fifo_count - 2'd1;
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    // FIFO storage; data words carry no reset.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= p_in;
        end
    end

    // Request/dispatch counters and round-robin pointer; all cleared when a
    // new frame starts, otherwise the dispatch count holds through IDLE.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_inflight       <= 1'b0;
            r_req_count      <= 16'd0;
            r_dispatch_count <= 16'd0;
            r_rr_ptr         <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_frame_go) begin
                r_req_count      <= 16'd0;
                r_dispatch_count <= 16'd0;
                r_rr_ptr         <= '0;
            end else begin
                if (w_req) begin
                    r_req_count <= r_req_count + 16'd1;
                end
                if (w_pop) begin
                    r_dispatch_count <= r_dispatch_count + 16'd1;
                    r_rr_ptr         <= f_lane_next(w_grant);
                end
            end
        end
    end

    assign busy_out           = ~w_req;
    assign lane_data_out      = r_mem[r_rd_ptr];
    assign lane_valid_out     = w_lane_valid;
    assign frame_active_out   = w_frame_active;
    assign frame_done_out     = w_frame_done;
    assign dispatch_count_out = r_dispatch_count;

endmodule

// File: tb/tb_particle_dispatch.sv
// Bench for particle_dispatch: a 1-cycle-latency source model feeds a
// scoreboard queue; a negedge monitor pops and checks every lane transfer.
module tb_particle_dispatch;

    localparam int NP = 4;
    localparam int NL = 2;
    localparam int DW = 48;

    logic          clk = 1'b0;
    logic          rst_in = 1'b1;
    logic          frame_start_in = 1'b0;
    logic [DW-1:0] p_in = '0;
    logic          p_valid_in = 1'b0;
    logic          busy_out;
    logic [DW-1:0] lane_data_out;
    logic [NL-1:0] lane_valid_out;
    logic [NL-1:0] lane_ready_in = '0;
    logic [NL-1:0] lane_busy_in = '0;
    logic          frame_active_out;
    logic          frame_done_out;
    logic [15:0]   dispatch_count_out;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] sb_q[$];
    int            lane_log[$];
    int            done_cnt = 0;
    int            words_sent = 0;
    int            rr_model = 0;
    logic [15:0]   seq = 16'h0100;
    bit            pending = 1'b0;
    bit            inject_junk = 1'b0;

    particle_dispatch #(
        .NUM_PARTICLES(NP),
        .NUM_LANES    (NL),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk_in            (clk),
        .rst_in            (rst_in),
        .frame_start_in    (frame_start_in),
        .p_in              (p_in),
        .p_valid_in        (p_valid_in),
        .busy_out          (busy_out),
        .lane_data_out     (lane_data_out),
        .lane_valid_out    (lane_valid_out),
        .lane_ready_in     (lane_ready_in),
        .lane_busy_in      (lane_busy_in),
        .frame_active_out  (frame_active_out),
        .frame_done_out    (frame_done_out),
        .dispatch_count_out(dispatch_count_out)
    );

    always #5 clk = ~clk;

    // Monitor then source model, both on the falling edge.
    always @(negedge clk) begin : mon
        logic [NL-1:0] exp_v;
        logic [NL-1:0] xfer;
        int            g;
        int            idx;
        if (frame_done_out === 1'b1) done_cnt++;
        if (rst_in) begin
            sb_q.delete();
            pending    = 1'b0;
            p_valid_in = 1'b0;
            rr_model   = 0;
        end else begin
            exp_v = '0;
            if (sb_q.size() > 0) begin
                for (int k = 0; k < NL; k++) begin
                    idx = (rr_model + k) % NL;
                    if (exp_v == '0 && lane_ready_in[idx]) exp_v[idx] = 1'b1;
                end
            end
            n_cmp++;
            if (lane_valid_out !== exp_v) begin
                n_err++;
                $display("FAIL lane_valid: got %b expected %b at %0t", lane_valid_out, exp_v, $time);
            end
            xfer = lane_valid_out & lane_ready_in;
            if (xfer != '0 && sb_q.size() > 0) begin
                g = 0;
                for (int k = 0; k < NL; k++) if (xfer[k]) g = k;
                n_cmp++;
                if (lane_data_out !== sb_q[0]) begin
                    n_err++;
                    $display("FAIL lane_data: got %h expected %h at %0t", lane_data_out, sb_q[0], $time);
                end
                void'(sb_q.pop_front());
                lane_log.push_back(g);
                rr_model = (g + 1) % NL;
            end
            if (pending) begin
                p_valid_in = 1'b1;
                p_in       = {seq, seq ^ 16'h5A5A, ~seq};
                sb_q.push_back(p_in);
                seq++;
                words_sent++;
            end else if (inject_junk) begin
                p_valid_in = 1'b1;
                p_in       = 48'hDEAD_0BAD_F00D;
            end else begin
                p_valid_in = 1'b0;
            end
            pending = (busy_out === 1'b0);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_frame(input bit fresh);
        frame_start_in = 1'b1;
        if (fresh) begin
            rr_model   = 0;
            words_sent = 0;
            lane_log.delete();
        end
        tick();
        frame_start_in = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_log(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (lane_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        lane_ready_in = 2'b11;
        rst_in = 1'b1;
        tick(2);
        n_cmp++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy_out); end
        n_cmp++; if (lane_valid_out !== 2'b00) begin n_err++; $display("FAIL reset_valid: got %b want 00", lane_valid_out); end
        n_cmp++; if (frame_active_out !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", frame_active_out); end
        n_cmp++; if (frame_done_out !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", frame_done_out); end
        n_cmp++; if (dispatch_count_out !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", dispatch_count_out); end
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int d0;
        bit ok;
        lane_ready_in = 2'b11;
        lane_busy_in  = 2'b00;
        d0 = done_cnt;
        start_frame(1'b1);
        n_cmp++; if (frame_active_out !== 1'b1) begin n_err++; $display("FAIL basic_active: got %b want 1", frame_active_out); end
        wait_done(d0, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_timeout: got no frame_done want one"); end
        tick(5);
        n_cmp++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (dispatch_count_out !== 16'd4) begin n_err++; $display("FAIL basic_count: got %0d want 4", dispatch_count_out); end
        n_cmp++; if (lane_log.size() !== 4) begin n_err++; $display("FAIL basic_nlog: got %0d want 4", lane_log.size()); end
        for (int i = 0; i < lane_log.size(); i++) begin
            n_cmp++; if (lane_log[i] !== i % 2) begin n_err++; $display("FAIL basic_lane%0d: got %0d want %0d", i, lane_log[i], i % 2); end
        end
        n_cmp++; if (words_sent !== 4) begin n_err++; $display("FAIL basic_words: got %0d want 4", words_sent); end
    endtask

    task automatic test_stall();
        int d0;
        bit ok;
        lane_ready_in = 2'b00;
        d0 = done_cnt;
        start_frame(1'b1);
        tick(10);
        n_cmp++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL stall_busy: got %b want 1", busy_out); end
        n_cmp++; if (words_sent !== 2) begin n_err++; $display("FAIL stall_words: got %0d want 2", words_sent); end
        n_cmp++; if (dispatch_count_out !== 16'd0) begin n_err++; $display("FAIL stall_count: got %0d want 0", dispatch_count_out); end
        lane_ready_in = 2'b11;
        wait_done(d0, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_timeout: got no frame_done want one"); end
        tick(2);
        n_cmp++; if (dispatch_count_out !== 16'd4) begin n_err++; $display("FAIL stall_count_end: got %0d want 4", dispatch_count_out); end
        n_cmp++; if (words_sent !== 4) begin n_err++; $display("FAIL stall_words_end: got %0d want 4", words_sent); end
        n_cmp++; if (sb_q.size() !== 0) begin n_err++; $display("FAIL stall_left: got %0d words want 0", sb_q.size()); end
        for (int i = 0; i < lane_log.size(); i++) begin
            n_cmp++; if (lane_log[i] !== i % 2) begin n_err++; $display("FAIL stall_lane%0d: got %0d want %0d", i, lane_log[i], i % 2); end
        end
    endtask

    task automatic test_rr_lane1();
        int d0;
        bit ok;
        lane_ready_in = 2'b10;
        d0 = done_cnt;
        start_frame(1'b1);
        wait_log(1, 100, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_timeout: got no dispatch want one"); end
        if (lane_log.size() > 0) begin
            n_cmp++; if (lane_log[0] !== 1) begin n_err++; $display("FAIL rr_first: got lane %0d want 1", lane_log[0]); end
        end
        lane_ready_in = 2'b11;
        wait_done(d0, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_done_timeout: got no frame_done want one"); end
        n_cmp++; if (lane_log.size() !== 4) begin n_err++; $display("FAIL rr_nlog: got %0d want 4", lane_log.size()); end
        for (int i = 0; i < lane_log.size(); i++) begin
            n_cmp++; if (lane_log[i] !== 1 - (i % 2)) begin n_err++; $display("FAIL rr_lane%0d: got %0d want %0d", i, lane_log[i], 1 - (i % 2)); end
        end
    endtask

    task automatic test_drain();
        int d0;
        bit ok;
        lane_ready_in = 2'b11;
        lane_busy_in  = 2'b10;
        d0 = done_cnt;
        start_frame(1'b1);
        wait_log(4, 100, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL drain_timeout: got %0d dispatches want 4", lane_log.size()); end
        tick(3);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (frame_active_out !== 1'b1) begin n_err++; $display("FAIL drain_hold%0d: got active %b want 1", i, frame_active_out); end
        end
        n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL drain_early_done: got %0d pulses want 0", done_cnt - d0); end
        lane_busy_in = 2'b00;
        tick();
        n_cmp++; if (frame_done_out !== 1'b1) begin n_err++; $display("FAIL drain_done: got %b want 1", frame_done_out); end
        tick();
        n_cmp++; if (frame_done_out !== 1'b0) begin n_err++; $display("FAIL drain_done_width: got %b want 0", frame_done_out); end
        n_cmp++; if (frame_active_out !== 1'b0) begin n_err++; $display("FAIL drain_idle: got active %b want 0", frame_active_out); end
        n_cmp++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL drain_pulses: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_ignore();
        int d0;
        bit ok;
        lane_ready_in = 2'b00;
        d0 = done_cnt;
        start_frame(1'b1);
        tick(4);
        start_frame(1'b0);
        n_cmp++; if (frame_active_out !== 1'b1) begin n_err++; $display("FAIL ign_active: got %b want 1", frame_active_out); end
        n_cmp++; if (words_sent !== 2) begin n_err++; $display("FAIL ign_words_mid: got %0d want 2", words_sent); end
        lane_ready_in = 2'b11;
        wait_done(d0, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL ign_timeout: got no frame_done want one"); end
        tick(2);
        n_cmp++; if (dispatch_count_out !== 16'd4) begin n_err++; $display("FAIL ign_count: got %0d want 4", dispatch_count_out); end
        n_cmp++; if (words_sent !== 4) begin n_err++; $display("FAIL ign_words: got %0d want 4", words_sent); end
        n_cmp++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL ign_pulses: got %0d want 1", done_cnt - d0); end
        inject_junk = 1'b1;
        tick(4);
        inject_junk = 1'b0;
        tick(2);
        n_cmp++; if (frame_active_out !== 1'b0) begin n_err++; $display("FAIL junk_active: got %b want 0", frame_active_out); end
        n_cmp++; if (dispatch_count_out !== 16'd4) begin n_err++; $display("FAIL junk_count: got %0d want 4", dispatch_count_out); end
        n_cmp++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL junk_busy: got %b want 1", busy_out); end
    endtask

    task automatic test_reset_mid();
        int d0;
        bit ok;
        lane_ready_in = 2'b11;
        d0 = done_cnt;
        start_frame(1'b1);
        wait_log(2, 100, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rstm_timeout: got %0d dispatches want 2", lane_log.size()); end
        rst_in = 1'b1;
        tick();
        n_cmp++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL rstm_busy: got %b want 1", busy_out); end
        n_cmp++; if (lane_valid_out !== 2'b00) begin n_err++; $display("FAIL rstm_valid: got %b want 00", lane_valid_out); end
        n_cmp++; if (frame_active_out !== 1'b0) begin n_err++; $display("FAIL rstm_active: got %b want 0", frame_active_out); end
        n_cmp++; if (frame_done_out !== 1'b0) begin n_err++; $display("FAIL rstm_done: got %b want 0", frame_done_out); end
        n_cmp++; if (dispatch_count_out !== 16'd0) begin n_err++; $display("FAIL rstm_count: got %0d want 0", dispatch_count_out); end
        rst_in = 1'b0;
        tick(5);
        n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL rstm_no_done: got %0d pulses want 0", done_cnt - d0); end
        d0 = done_cnt;
        start_frame(1'b1);
        wait_done(d0, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rstm_refr_timeout: got no frame_done want one"); end
        tick(2);
        n_cmp++; if (dispatch_count_out !== 16'd4) begin n_err++; $display("FAIL rstm_refr_count: got %0d want 4", dispatch_count_out); end
        n_cmp++; if (words_sent !== 4) begin n_err++; $display("FAIL rstm_refr_words: got %0d want 4", words_sent); end
        n_cmp++; if (sb_q.size() !== 0) begin n_err++; $display("FAIL rstm_refr_left: got %0d want 0", sb_q.size()); end
        for (int i = 0; i < lane_log.size(); i++) begin
            n_cmp++; if (lane_log[i] !== i % 2) begin n_err++; $display("FAIL rstm_lane%0d: got %0d want %0d", i, lane_log[i], i % 2); end
        end
    endtask

    initial begin
        tick(3);
        test_reset();
        test_basic();
        test_stall();
        test_rr_lane1();
        test_drain();
        test_ignore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion want finish within 200us");
        $fatal(1, "bench timeout");
    end

endmodule
